retro_catc_stall_gen: RTL

Core-side bus bridge that generates the `Delay` request consumed by the CATC clock-enable controller. It forwards an emulated core's memory access to slow external memory (SDRAM, load image) and asserts `Delay` only for latency that exceeds the core's native cycle budget, so CATC can later recover exactly the stalled time. Sits between the core bus, the external memory port and the CATC `Delay` input.

---
 rtl/retro_catc_pkg.sv | 33 +++
 rtl/retro_sat_counter.sv | 41 ++++
 rtl/retro_catc_stall_gen.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/retro_catc_pkg.sv
// Shared types for the CATC stall generator: FSM states, stall event record
// and the saturating stall-length helper.
package retro_catc_pkg;

  localparam int CATC_STALLMAX_W = 16;
  localparam int CATC_STALLCNT_W = 20;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_STALL = 2'd2,
    ST_DONE  = 2'd3
  } catc_stall_state_t;

  typedef struct packed {
    logic                       timeout;
    logic [CATC_STALLMAX_W-1:0] stall_len;
  } catc_stall_stats_t;

  // Stall length including the current STALL cycle, clipped to the StallMax width.
  function automatic logic [CATC_STALLMAX_W-1:0] sat_stall_len(
    input logic [CATC_STALLCNT_W-1:0] cnt
  );
    logic [CATC_STALLCNT_W:0] len;
    len = {1'b0, cnt} + {{CATC_STALLCNT_W{1'b0}}, 1'b1};
    if (|len[CATC_STALLCNT_W:CATC_STALLMAX_W]) begin
      return {CATC_STALLMAX_W{1'b1}};
    end else begin
      return len[CATC_STALLMAX_W-1:0];
    end
  endfunction

endpackage

// File: rtl/retro_sat_counter.sv
// Saturating up-counter with synchronous clear (highest priority) and load.
module retro_sat_counter #(
  parameter int Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             inc_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] count_q, count_d;

  // Next count: clear beats load, load beats increment, increment stops at all ones.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = {Width{1'b0}};
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (inc_i && (count_q != {Width{1'b1}})) begin
      count_d = count_q + Width'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= {Width{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/retro_catc_stall_gen.sv
// Core-to-memory bridge that raises Delay only for latency beyond the core's
// native cycle budget, with timeout abort and stall statistics.
module retro_catc_stall_gen
  import retro_catc_pkg::*;
#(
  parameter int AddrWidth     = 16,
  parameter int DataWidth     = 8,
  parameter int Budget        = 8,
  parameter int TimeoutCycles = 65535,
  parameter int StatWidth     = 32
) (
  input  logic                       Clk,
  input  logic                       Reset_n,
  input  logic                       CeIn,
  input  logic                       CoreReq,
  input  logic                       CoreWrite,
  input  logic [AddrWidth-1:0]       CoreAddr,
  input  logic [DataWidth-1:0]       CoreWData,
  output logic                       CoreAck,
  output logic [DataWidth-1:0]       CoreRData,
  output logic                       MemReqValid,
  input  logic                       MemReqReady,
  output logic                       MemWrite,
  output logic [AddrWidth-1:0]       MemAddr,
  output logic [DataWidth-1:0]       MemWData,
  input  logic                       MemRespValid,
  input  logic [DataWidth-1:0]       MemRData,
  output logic                       Delay,
  output logic                       Error,
  input  logic                       StatClear,
  output logic [StatWidth-1:0]       StallTotal,
  output logic [CATC_STALLMAX_W-1:0] StallMax
);

  catc_stall_state_t state_q, state_d;
  logic                 mem_req_valid_q, mem_req_valid_d;
  logic                 mem_write_q, mem_write_d;
  logic [AddrWidth-1:0] mem_addr_q, mem_addr_d;
  logic [DataWidth-1:0] mem_wdata_q, mem_wdata_d;
  logic                 hs_done_q, hs_done_d;
  logic [7:0]           budget_q, budget_d;
  logic [DataWidth-1:0] core_rdata_q, core_rdata_d;
  logic                 core_ack_q, core_ack_d;
  logic                 delay_q, delay_d;
  logic                 error_q, error_d;

  logic [CATC_STALLCNT_W-1:0] stall_cnt_s;
  logic [CATC_STALLMAX_W-1:0] stall_max_s;
  logic [StatWidth-1:0]       stall_total_s;
  catc_stall_stats_t          stall_evt_s;
  logic capture_s, handshake_s, resp_ok_s, timeout_s, in_stall_s, max_load_s;

  assign in_stall_s  = (state_q == ST_STALL);
  assign capture_s   = CeIn && CoreReq && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign handshake_s = mem_req_valid_q && MemReqReady;
  // A response only counts once the request has been (or is being) accepted.
  assign resp_ok_s   = MemRespValid && (hs_done_q || handshake_s);
  assign timeout_s   = (stall_cnt_s == CATC_STALLCNT_W'(TimeoutCycles - 1));
  assign max_load_s  = in_stall_s && (state_d != ST_STALL) && (stall_evt_s.stall_len > stall_max_s);

  // Next-state, request/response bookkeeping and output register inputs.
  always_comb begin
    state_d              = state_q;
    mem_write_d          = mem_write_q;
    mem_addr_d           = mem_addr_q;
    mem_wdata_d          = mem_wdata_q;
    budget_d             = budget_q;
    core_rdata_d         = core_rdata_q;
    core_ack_d           = core_ack_q;
    stall_evt_s.timeout  = 1'b0;
    stall_evt_s.stall_len = sat_stall_len(stall_cnt_s);
    if (handshake_s) begin
      mem_req_valid_d = 1'b0;
      hs_done_d       = 1'b1;
    end else begin
      mem_req_valid_d = mem_req_valid_q;
      hs_done_d       = hs_done_q;
    end

    case (state_q)
      ST_IDLE: begin
        state_d = capture_s ? ST_WAIT : ST_IDLE;
      end
      ST_WAIT: begin
        budget_d = (budget_q != 8'd0) ? (budget_q - 8'd1) : budget_q;
        if (resp_ok_s) begin
          core_rdata_d = mem_write_q ? core_rdata_q : MemRData;
          core_ack_d   = 1'b1;
          state_d      = ST_DONE;
        end else if (budget_q == 8'd0) begin
          state_d = ST_STALL;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_STALL: begin
        if (resp_ok_s) begin
          core_rdata_d = mem_write_q ? core_rdata_q : MemRData;
          core_ack_d   = 1'b1;
          state_d      = ST_DONE;
        end else if (timeout_s) begin
          stall_evt_s.timeout = 1'b1;
          core_rdata_d        = {DataWidth{1'b1}};
          core_ack_d          = 1'b1;
          mem_req_valid_d     = 1'b0;
          state_d             = ST_DONE;
        end else begin
          state_d = ST_STALL;
        end
      end
      ST_DONE: begin
        if (CeIn) begin
          core_ack_d = 1'b0;
          state_d    = CoreReq ? ST_WAIT : ST_IDLE;
        end else begin
          core_ack_d = 1'b1;
          state_d    = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    mem_req_valid_d = capture_s ? 1'b1 : mem_req_valid_d;
    hs_done_d       = capture_s ? 1'b0 : hs_done_d;
    mem_write_d     = capture_s ? CoreWrite : mem_write_d;
    mem_addr_d      = capture_s ? CoreAddr : mem_addr_d;
    mem_wdata_d     = capture_s ? CoreWData : mem_wdata_d;
    budget_d        = capture_s ? 8'(Budget - 1) : budget_d;
    error_d         = StatClear ? 1'b0 : (error_q | stall_evt_s.timeout);
    delay_d         = (state_d == ST_STALL);
  end

  // State and registered outputs.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q         <= ST_IDLE;
      mem_req_valid_q <= 1'b0;
      mem_write_q     <= 1'b0;
      mem_addr_q      <= {AddrWidth{1'b0}};
      mem_wdata_q     <= {DataWidth{1'b0}};
      hs_done_q       <= 1'b0;
      budget_q        <= 8'd0;
      core_rdata_q    <= {DataWidth{1'b0}};
      core_ack_q      <= 1'b0;
      delay_q         <= 1'b0;
      error_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_write_q     <= mem_write_d;
      mem_addr_q      <= mem_addr_d;
      mem_wdata_q     <= mem_wdata_d;
      hs_done_q       <= hs_done_d;
      budget_q        <= budget_d;
      core_rdata_q    <= core_rdata_d;
      core_ack_q      <= core_ack_d;
      delay_q         <= delay_d;
      error_q         <= error_d;
    end
  end

  retro_sat_counter #(.Width(CATC_STALLCNT_W)) u_stall_cnt (
    .clk_i      (Clk),
    .rst_ni     (Reset_n),
    .clear_i    (!in_stall_s),
    .load_i     (1'b0),
    .load_val_i ({CATC_STALLCNT_W{1'b0}}),
    .inc_i      (in_stall_s),
    .count_o    (stall_cnt_s)
  );

  retro_sat_counter #(.Width(StatWidth)) u_stall_total (
    .clk_i      (Clk),
    .rst_ni     (Reset_n),
    .clear_i    (StatClear),
    .load_i     (1'b0),
    .load_val_i ({StatWidth{1'b0}}),
    .inc_i      (delay_q),
    .count_o    (stall_total_s)
  );

  retro_sat_counter #(.Width(CATC_STALLMAX_W)) u_stall_max (
    .clk_i      (Clk),
    .rst_ni     (Reset_n),
    .clear_i    (StatClear),
    .load_i     (max_load_s),
    .load_val_i (stall_evt_s.stall_len),
    .inc_i      (1'b0),
    .count_o    (stall_max_s)
  );

  assign CoreAck     = core_ack_q;
  assign CoreRData   = core_rdata_q;
  assign MemReqValid = mem_req_valid_q;
  assign MemWrite    = mem_write_q;
  assign MemAddr     = mem_addr_q;
  assign MemWData    = mem_wdata_q;
  assign Delay       = delay_q;
  assign Error       = error_q;
  assign StallTotal  = stall_total_s;
  assign StallMax    = stall_max_s;

endmodule
